// File: rtl/wb_pkg.sv
// Shared types for the Wishbone FIFO device: response encoding and FSM states.
package wb_pkg;

    typedef enum logic [1:0] {WB_NONE, WB_ACK, WB_ERR, WB_RTY} wb_resp_t;

    typedef enum logic {ST_IDLE, ST_RESP} wb_dev_state_t;

endpackage

// File: rtl/wishbone_classic.sv
// Wishbone classic bus bundle; the controller and device modports share one clock domain.
interface wishbone_classic #(
    parameter int DAT_WIDTH = 8
);
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [DAT_WIDTH-1:0] wdat;
    logic [DAT_WIDTH-1:0] rdat;
    logic                 ack;
    logic                 err;
    logic                 rty;

    modport controller (output cyc, stb, we, wdat, input rdat, ack, err, rty);
    modport device     (input cyc, stb, we, wdat, output rdat, ack, err, rty);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with separate occupancy counter.
module sync_fifo #(
    parameter int DAT_WIDTH = 8,
    parameter int DEPTH     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DAT_WIDTH-1:0]       wdata_i,
    output logic [DAT_WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [DAT_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;
    logic                 push_s;
    logic                 pop_s;

    assign push_s  = push_i && (count_r != CNT_FULL);
    assign pop_s   = pop_i && (count_r != {(AW+1){1'b0}});
    assign rdata_o = mem_r[rd_ptr_r];
    assign count_o = count_r;
    assign full_o  = (count_r == CNT_FULL);
    assign empty_o = (count_r == {(AW+1){1'b0}});

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata_i;
        end
    end

    // Pointers wrap naturally at DEPTH; the counter disambiguates full from empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_fifo_device.sv
// Wishbone classic device: writes push into a FIFO, reads pop from it, one
// registered ACK/ERR/RTY per request.
module wb_fifo_device
    import wb_pkg::*;
#(
    parameter int DAT_WIDTH = 8,
    parameter int DEPTH     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    wishbone_classic.device        wb,
    input  logic                   en_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    wb_dev_state_t        state_r;
    wb_dev_state_t        state_nxt_s;
    wb_resp_t             resp_nxt_s;
    logic                 req_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [DAT_WIDTH-1:0] fifo_rdata_s;
    logic [DAT_WIDTH-1:0] dat_r;
    logic                 ack_r;
    logic                 err_r;
    logic                 rty_r;

    assign req_s = wb.cyc && wb.stb;

    sync_fifo #(
        .DAT_WIDTH (DAT_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (wb.wdat),
        .rdata_o (fifo_rdata_s),
        .count_o (count_o),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next state, request classification and FIFO strobes.
    always_comb begin
        state_nxt_s = state_r;
        resp_nxt_s  = WB_NONE;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt_s = ST_RESP;
                    if (!en_i) begin
                        resp_nxt_s = WB_ERR;
                    end else if (wb.we && fifo_full_s) begin
                        resp_nxt_s = WB_RTY;
                    end else if (!wb.we && fifo_empty_s) begin
                        resp_nxt_s = WB_RTY;
                    end else if (wb.we) begin
                        push_s     = 1'b1;
                        resp_nxt_s = WB_ACK;
                    end else begin
                        pop_s      = 1'b1;
                        resp_nxt_s = WB_ACK;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, response flops and read-data register; responses only ever last one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rty_r   <= 1'b0;
            dat_r   <= {DAT_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ack_r   <= (resp_nxt_s == WB_ACK);
            err_r   <= (resp_nxt_s == WB_ERR);
            rty_r   <= (resp_nxt_s == WB_RTY);
            if (pop_s) begin
                dat_r <= fifo_rdata_s;
            end
        end
    end

    assign wb.ack  = ack_r;
    assign wb.err  = err_r;
    assign wb.rty  = rty_r;
    assign wb.rdat = dat_r;
    assign full_o  = fifo_full_s;
    assign empty_o = fifo_empty_s;

endmodule

// File: tb/tb_wb_fifo_device.sv
// Directed self-checking bench for wb_fifo_device (DAT_WIDTH=8, DEPTH=16).
module tb_wb_fifo_device;

    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_ACK  = 3'b100;
    localparam logic [2:0] R_ERR  = 3'b010;
    localparam logic [2:0] R_RTY  = 3'b001;

    logic       clk;
    logic       rst;
    logic       en;
    logic [4:0] count;
    logic       full;
    logic       empty;
    int         total;
    int         bad;
    int         acks;

    wishbone_classic #(.DAT_WIDTH(8)) bus ();

    wb_fifo_device #(
        .DAT_WIDTH (8),
        .DEPTH     (16)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .wb      (bus),
        .en_i    (en),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic xfer(input logic we, input logic [7:0] d, input logic [2:0] exp_resp,
                        input logic [7:0] exp_dat, input logic chk_dat, input int exp_cnt,
                        input string tag);
        bus.cyc  = 1'b1;
        bus.stb  = 1'b1;
        bus.we   = we;
        bus.wdat = d;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_resp"}, 32'({bus.ack, bus.err, bus.rty}), 32'(exp_resp));
        chk({tag, "_cnt"}, 32'(count), 32'(exp_cnt));
        if (chk_dat) chk({tag, "_dat"}, 32'(bus.rdat), 32'(exp_dat));
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle"}, 32'({bus.ack, bus.err, bus.rty}), 32'(R_NONE));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        en       = 1'b1;
        bus.cyc  = 1'b0;
        bus.stb  = 1'b0;
        bus.we   = 1'b0;
        bus.wdat = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_resp", 32'({bus.ack, bus.err, bus.rty}), 32'(R_NONE));
        chk("rst_dat", 32'(bus.rdat), 32'h0);
        chk("rst_cnt", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        xfer(1'b0, 8'h00, R_RTY, 8'h00, 1'b1, 0, "rd_empty");

        xfer(1'b1, 8'h11, R_ACK, 8'h00, 1'b0, 1, "wr11");
        xfer(1'b1, 8'h22, R_ACK, 8'h00, 1'b0, 2, "wr22");
        xfer(1'b1, 8'h33, R_ACK, 8'h00, 1'b0, 3, "wr33");
        xfer(1'b0, 8'h00, R_ACK, 8'h11, 1'b1, 2, "rd11");
        xfer(1'b0, 8'h00, R_ACK, 8'h22, 1'b1, 1, "rd22");
        xfer(1'b0, 8'h00, R_ACK, 8'h33, 1'b1, 0, "rd33");

        for (int i = 0; i < 16; i++) begin
            xfer(1'b1, 8'(i), R_ACK, 8'h00, 1'b0, i + 1, $sformatf("fill%0d", i));
        end
        xfer(1'b1, 8'hFF, R_RTY, 8'h00, 1'b0, 16, "wr_full");
        chk("full_flag", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 8'h00, R_ACK, 8'(i), 1'b1, 15 - i, $sformatf("drain%0d", i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_full", 32'(full), 32'd0);

        en = 1'b0;
        xfer(1'b1, 8'hAA, R_ERR, 8'h00, 1'b0, 0, "dis_wr");
        en = 1'b1;
        xfer(1'b1, 8'hAA, R_ACK, 8'h00, 1'b0, 1, "en_wr");
        xfer(1'b0, 8'h00, R_ACK, 8'hAA, 1'b1, 0, "en_rd");

        acks     = 0;
        bus.cyc  = 1'b1;
        bus.stb  = 1'b1;
        bus.we   = 1'b1;
        bus.wdat = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("hold_c%0d", i), 32'(bus.ack), 32'((i % 2) == 0));
            if (bus.ack) acks++;
        end
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        chk("hold_acks", 32'(acks), 32'd3);
        chk("hold_cnt", 32'(count), 32'd3);

        bus.cyc  = 1'b1;
        bus.stb  = 1'b1;
        bus.we   = 1'b1;
        bus.wdat = 8'h44;
        @(posedge clk);
        @(negedge clk);
        chk("prerst_ack", 32'(bus.ack), 32'd1);
        chk("prerst_cnt", 32'(count), 32'd4);
        rst     = 1'b1;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        #1;
        chk("midrst_ack", 32'(bus.ack), 32'd0);
        chk("midrst_cnt", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(1'b0, 8'h00, R_RTY, 8'h00, 1'b1, 0, "postrst_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
